// File: rtl/lsb_mem_port.sv
// Byte-serial responder between the load/store buffer and the 8-bit RAM/IO bus.
// Define MEMCTRL_IO_STALL_EN to hold IO-window stores while io_buffer_full is set.
module lsb_mem_port #(
    parameter logic [31:0] IO_BASE = 32'h00030000,
    parameter int          RAM_LAT = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_flag,
    input  logic        full_mem,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  op,
    output logic        mem_ready,
    output logic [31:0] mem_val,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic        restart, restart_n;
    logic [31:0] req_addr_p0, req_addr_n;
    logic [31:0] req_data_p0, req_data_n;
    logic [2:0]  req_op_p0, req_op_n;
    logic [31:0] ld_buf, ld_buf_n;
    logic        wr_q, wr_n;
    logic        ready_n;
    logic [31:0] val_n;
    logic [31:0] a_n;
    logic [7:0]  dout_n;
    logic [2:0]  nbytes;
    logic [2:0]  cnt_inc;
    logic [1:0]  next_idx;
    logic        stall;

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] kind);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = raw[7:0];
        h = raw[15:0];
        s = 32'(h);
        if (kind[1]) begin
            s = raw;
        end else if (kind[0]) begin
            s = kind[2] ? {16'b0, raw[15:0]} : 32'(h);
        end else begin
            s = kind[2] ? {24'b0, raw[7:0]} : 32'(b);
        end
        return s;
    endfunction

`ifdef MEMCTRL_IO_STALL_EN
    logic io_hit;
    assign io_hit = (req_addr_p0 - IO_BASE) < 32'd8;
    assign stall  = (state == STORE) && io_hit && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign stall     = 1'b0;
`endif

    always_comb begin
        unique case (req_op_p0[1:0])
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign cnt_inc  = cnt + 3'd1;
    assign next_idx = cnt_inc[1:0];
    assign mem_wr   = wr_q & rdy_in & ~stall;
    assign busy     = (state != IDLE);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        restart_n  = restart;
        req_addr_n = req_addr_p0;
        req_data_n = req_data_p0;
        req_op_n   = req_op_p0;
        ld_buf_n   = ld_buf;
        wr_n       = wr_q;
        ready_n    = mem_ready;
        val_n      = mem_val;
        a_n        = mem_a;
        dout_n     = mem_dout;
        unique case (state)
            IDLE: begin
                if (full_mem && rdy_in && !clear_flag) begin
                    req_addr_n = addr;
                    req_data_n = data;
                    req_op_n   = op[2:0];
                    cnt_n      = 3'd0;
                    restart_n  = 1'b0;
                    a_n        = addr;
                    if (op[3]) begin
                        state_n = STORE;
                        dout_n  = data[7:0];
                        wr_n    = 1'b1;
                    end else begin
                        state_n = LOAD;
                        wr_n    = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (clear_flag) begin
                    state_n   = IDLE;
                    cnt_n     = 3'd0;
                    restart_n = 1'b0;
                end else if (!rdy_in) begin
                    // A paused load loses its in-flight byte, so replay from byte 0.
                    restart_n = 1'b1;
                end else if (restart) begin
                    restart_n = 1'b0;
                    cnt_n     = 3'd0;
                    a_n       = req_addr_p0;
                end else if (cnt == nbytes + LAT - 3'd1) begin
                    val_n   = extend_load(ld_buf, req_op_p0);
                    ready_n = 1'b1;
                    state_n = DONE;
                end else begin
                    ld_buf_n[{cnt[1:0], 3'b000} +: 8] = mem_din;
                    if (cnt_inc < nbytes) begin
                        a_n = req_addr_p0 + {29'b0, cnt_inc};
                    end
                    cnt_n = cnt_inc;
                end
            end
            STORE: begin
                // Stores are already committed, so a flush does not cut them short.
                if (rdy_in && !stall) begin
                    if (cnt_inc < nbytes) begin
                        a_n    = req_addr_p0 + {29'b0, cnt_inc};
                        dout_n = req_data_p0[{next_idx, 3'b000} +: 8];
                        cnt_n  = cnt_inc;
                    end else begin
                        wr_n    = 1'b0;
                        ready_n = 1'b1;
                        val_n   = 32'd0;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (rdy_in) begin
                    ready_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            restart   <= 1'b0;
            wr_q      <= 1'b0;
            mem_ready <= 1'b0;
            mem_val   <= 32'd0;
            mem_a     <= 32'd0;
            mem_dout  <= 8'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            restart   <= restart_n;
            wr_q      <= wr_n;
            mem_ready <= ready_n;
            mem_val   <= val_n;
            mem_a     <= a_n;
            mem_dout  <= dout_n;
        end
    end

    always_ff @(posedge clk_in) begin
        req_addr_p0 <= req_addr_n;
        req_data_p0 <= req_data_n;
        req_op_p0   <= req_op_n;
        ld_buf      <= ld_buf_n;
    end
endmodule

// File: tb/tb_lsb_mem_port.sv
// Bench for lsb_mem_port: vector table, directed flush/pause/stall/reset cases and random traffic
// checked against a byte-array memory model.
module tb_lsb_mem_port;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_flag, full_mem, io_buffer_full;
    logic [31:0] addr, data;
    logic [3:0]  op;
    logic        mem_ready, mem_wr, busy;
    logic [31:0] mem_val, mem_a;
    logic [7:0]  mem_din, mem_dout;

    lsb_mem_port dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .full_mem(full_mem), .addr(addr), .data(data), .op(op),
        .mem_ready(mem_ready), .mem_val(mem_val), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // Bus-side RAM: 1 KiB aliased over the address space, one-cycle read latency.
    logic [7:0]  ram   [0:1023];
    logic [7:0]  model [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_a = 10'd0;
    logic [7:0]  pre_d = 8'd0;
    logic [39:0] wr_log [$];

    assign mem_din = ram[mem_a[9:0]];

    always @(posedge clk_in) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
            wr_log.push_back({mem_a, mem_dout});
        end
    end

    int tests = 0;
    int fails = 0;
    int pause_at, pause_len, io_at, io_len, clr_at;
    logic [31:0] a_trace [0:31];
    logic        b_trace [0:31];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_val;
        int          exp_lat;
    } vec_t;
    vec_t vecs [0:12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    function automatic int nb(input logic [3:0] o);
        case (o[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] o, input logic [31:0] a);
        logic [31:0] raw;
        logic [31:0] p;
        raw = 32'd0;
        for (int i = 0; i < nb(o); i++) begin
            p   = a + 32'(i);
            raw = raw | ({24'b0, model[p[9:0]]} << (8 * i));
        end
        if (nb(o) == 1) return (o[2] || !raw[7]) ? raw : (raw | 32'hFFFFFF00);
        if (nb(o) == 2) return (o[2] || !raw[15]) ? raw : (raw | 32'hFFFF0000);
        return raw;
    endfunction

    task automatic model_store(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] p;
        logic [31:0] sh;
        for (int i = 0; i < nb(o); i++) begin
            p  = a + 32'(i);
            sh = d >> (8 * i);
            model[p[9:0]] = sh[7:0];
        end
    endtask

    task automatic clear_sched;
        pause_at = 0; pause_len = 0; io_at = 0; io_len = 0; clr_at = 0;
    endtask

    task automatic do_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                          input int budget, output int lat, output logic [31:0] val);
        full_mem = 1'b1; op = o; addr = a; data = d;
        tick;
        a_trace[0] = mem_a;
        b_trace[0] = busy;
        lat = -1;
        val = 32'd0;
        for (int k = 1; k <= budget; k++) begin
            rdy_in         = !(k >= pause_at && k < pause_at + pause_len);
            io_buffer_full = (k >= io_at && k < io_at + io_len);
            if (k == clr_at) begin
                clear_flag = 1'b1;
                full_mem   = 1'b0;
            end
            tick;
            clear_flag = 1'b0;
            a_trace[k] = mem_a;
            b_trace[k] = busy;
            if (mem_ready) begin
                lat = k;
                val = mem_val;
                break;
            end
        end
        full_mem = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
    endtask

    task automatic check_writes(input string name, input int base, input logic [3:0] o,
                                input logic [31:0] a, input logic [31:0] d);
        int n;
        logic [31:0] sh;
        n = o[3] ? nb(o) : 0;
        check({name, " write count"}, 32'(wr_log.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < wr_log.size(); i++) begin
            sh = d >> (8 * i);
            check({name, " write addr"}, wr_log[base + i][39:8], a + 32'(i));
            check({name, " write data"}, {24'b0, wr_log[base + i][7:0]}, {24'b0, sh[7:0]});
        end
    endtask

    task automatic check_idle_after(input string name);
        tick;
        check({name, " ready drops"}, {31'b0, mem_ready}, 32'd0);
        check({name, " busy drops"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, base, n_exp;
        logic [31:0] val, a, d;
        logic [3:0]  o;

        rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0; full_mem = 1'b0;
        io_buffer_full = 1'b0; addr = 32'd0; data = 32'd0; op = 4'd0;
        clear_sched();

        for (int i = 0; i < 1024; i++) model[i] = 8'($urandom);
        model[10'h100] = 8'h78; model[10'h101] = 8'h56; model[10'h102] = 8'h34;
        model[10'h103] = 8'h12; model[10'h104] = 8'hAA; model[10'h200] = 8'h80;
        model[10'h204] = 8'h34; model[10'h205] = 8'h92;
        model[10'h300] = 8'h11; model[10'h301] = 8'h22; model[10'h302] = 8'h33;
        model[10'h303] = 8'h44; model[10'h3FF] = 8'h9A; model[10'h000] = 8'hBC;
        model[10'h001] = 8'hDE; model[10'h002] = 8'hF0;

        vecs[0]  = '{4'b0010, 32'h0000_0100, 32'h0,         32'h1234_5678, 5};
        vecs[1]  = '{4'b0000, 32'h0000_0200, 32'h0,         32'hFFFF_FF80, 2};
        vecs[2]  = '{4'b0100, 32'h0000_0200, 32'h0,         32'h0000_0080, 2};
        vecs[3]  = '{4'b0001, 32'h0000_0204, 32'h0,         32'hFFFF_9234, 3};
        vecs[4]  = '{4'b0101, 32'h0000_0204, 32'h0,         32'h0000_9234, 3};
        vecs[5]  = '{4'b1001, 32'h0000_0301, 32'hDEAD_BEEF, 32'h0,         2};
        vecs[6]  = '{4'b0010, 32'h0000_0300, 32'h0,         32'h44BE_EF11, 5};
        vecs[7]  = '{4'b0011, 32'h0000_0101, 32'h0,         32'hAA12_3456, 5};
        vecs[8]  = '{4'b1010, 32'h0000_0380, 32'hCAFE_F00D, 32'h0,         4};
        vecs[9]  = '{4'b0100, 32'h0000_0381, 32'h0,         32'h0000_00F0, 2};
        vecs[10] = '{4'b0010, 32'hFFFF_FFFF, 32'h0,         32'hF0DE_BC9A, 5};
        vecs[11] = '{4'b1000, 32'h0000_0205, 32'h0000_007F, 32'h0,         1};
        vecs[12] = '{4'b0001, 32'h0000_0204, 32'h0,         32'h0000_7F34, 3};

        for (int i = 0; i < 1024; i++) begin
            pre_we = 1'b1; pre_a = 10'(i); pre_d = model[i];
            tick;
        end
        pre_we = 1'b0;

        check("reset mem_ready", {31'b0, mem_ready}, 32'd0);
        check("reset mem_val", mem_val, 32'd0);
        check("reset mem_a", mem_a, 32'd0);
        check("reset mem_dout", {24'b0, mem_dout}, 32'd0);
        check("reset mem_wr", {31'b0, mem_wr}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        rst_in = 1'b0;
        tick;

        for (int v = 0; v <= 12; v++) begin
            base = wr_log.size();
            do_req(vecs[v].op, vecs[v].addr, vecs[v].data, 20, lat, val);
            check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d mem_val", v), val, vecs[v].exp_val);
            check_writes($sformatf("vec%0d", v), base, vecs[v].op, vecs[v].addr, vecs[v].data);
            if (vecs[v].op[3]) model_store(vecs[v].op, vecs[v].addr, vecs[v].data);
            if (v == 0) begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("word load mem_a step %0d", k), a_trace[k], 32'h100 + 32'(k));
            end
            check_idle_after($sformatf("vec%0d", v));
        end

        // Flush during a word load, then a normal request.
        clr_at = 2;
        base = wr_log.size();
        do_req(4'b0010, 32'h100, 32'h0, 8, lat, val);
        check("clear load no ready", 32'(lat), 32'hFFFF_FFFF);
        check("clear load busy before", {31'b0, b_trace[1]}, 32'd1);
        check("clear load busy after", {31'b0, b_trace[2]}, 32'd0);
        check("clear load writes", 32'(wr_log.size() - base), 32'd0);
        clear_sched();
        do_req(4'b0000, 32'h200, 32'h0, 20, lat, val);
        check("after clear latency", 32'(lat), 32'd2);
        check("after clear mem_val", val, 32'hFFFF_FF80);
        check_idle_after("after clear");

        // Flush during a word store still completes it.
        clr_at = 2;
        base = wr_log.size();
        do_req(4'b1010, 32'h3B0, 32'h1357_9BDF, 20, lat, val);
        check("clear store latency", 32'(lat), 32'd4);
        check_writes("clear store", base, 4'b1010, 32'h3B0, 32'h1357_9BDF);
        model_store(4'b1010, 32'h3B0, 32'h1357_9BDF);
        clear_sched();
        check_idle_after("clear store");

        // rdy_in low for three edges starting at accept+2.
        pause_at = 2; pause_len = 3;
        base = wr_log.size();
        do_req(4'b0010, 32'h100, 32'h0, 20, lat, val);
        check("pause load latency", 32'(lat), 32'(pause_at + pause_len + 4 + 1));
        check("pause load mem_val", val, model_load(4'b0010, 32'h100));
        check("pause load restart addr", a_trace[pause_at + pause_len], 32'h100);
        check("pause load writes", 32'(wr_log.size() - base), 32'd0);
        check_idle_after("pause load");

        base = wr_log.size();
        do_req(4'b1010, 32'h3A0, 32'h0BAD_F00D, 20, lat, val);
        check("pause store latency", 32'(lat), 32'(4 + pause_len));
        check_writes("pause store", base, 4'b1010, 32'h3A0, 32'h0BAD_F00D);
        model_store(4'b1010, 32'h3A0, 32'h0BAD_F00D);
        clear_sched();
        check_idle_after("pause store");

        // Byte store into the IO window with the IO buffer full for four edges.
        io_at = 1; io_len = 4;
        base = wr_log.size();
        do_req(4'b1000, 32'h0003_0000, 32'h0000_005A, 20, lat, val);
`ifdef MEMCTRL_IO_STALL_EN
        check("io stall latency", 32'(lat), 32'd5);
`else
        check("io stall latency", 32'(lat), 32'd1);
`endif
        check_writes("io store", base, 4'b1000, 32'h0003_0000, 32'h0000_005A);
        model_store(4'b1000, 32'h0003_0000, 32'h0000_005A);
        clear_sched();
        check_idle_after("io store");

        // Reset in the middle of a word load.
        full_mem = 1'b1; op = 4'b0010; addr = 32'h101;
        tick;
        tick;
        rst_in = 1'b1; full_mem = 1'b0;
        tick;
        check("mid reset busy", {31'b0, busy}, 32'd0);
        check("mid reset mem_a", mem_a, 32'd0);
        check("mid reset mem_val", mem_val, 32'd0);
        check("mid reset mem_ready", {31'b0, mem_ready}, 32'd0);
        rst_in = 1'b0;
        tick;

        for (int r = 0; r < 40; r++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            d = $urandom;
            base = wr_log.size();
            do_req(o, a, d, 20, lat, val);
            n_exp = o[3] ? nb(o) : nb(o) + 1;
            check($sformatf("rand%0d latency", r), 32'(lat), 32'(n_exp));
            if (o[3]) begin
                check($sformatf("rand%0d store val", r), val, 32'd0);
                check_writes($sformatf("rand%0d", r), base, o, a, d);
                model_store(o, a, d);
            end else begin
                check($sformatf("rand%0d load val", r), val, model_load(o, a));
                check($sformatf("rand%0d load writes", r), 32'(wr_log.size() - base), 32'd0);
            end
            check_idle_after($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
